adder_seq_ctrl: RTL and testbench
=================================

// Module: adder_seq_ctrl
// PURPOSE
//  Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit
//  ripple adder (adder_4bits), one nibble per cycle, LSB first, with the carry held
//  in a register between cycles. Sits between a requester and a consumer, with
//  valid/ready handshakes on both sides. Trades NIBBLES cycles of latency for the
//  area of a single 4-bit adder.
// PARAMETERS
//  WIDTH    16   operand/result width; must be a multiple of 4 and >= 4
//  NIBBLES  WIDTH/4  localparam, derived; number of adder passes
//  CNT_W    $clog2(NIBBLES) (min 1)  localparam, derived; width of the nibble counter
// PORTS
//  i_w_clk      in   1      clock; all state updates on the rising edge
//  i_w_rst_n    in   1      asynchronous reset, active low
//  i_w_valid    in   1      request valid
//  o_w_ready    out  1      request accepted when i_w_valid && o_w_ready
//  i_w_a        in   WIDTH  operand A
//  i_w_b        in   WIDTH  operand B
//  i_w_cin      in   1      carry-in; ignored when i_w_sub=1
//  i_w_sub      in   1      1: compute A-B (B inverted, cin forced to 1)
//  o_w_valid    out  1      result valid
//  i_w_ready    in   1      result consumed when o_w_valid && i_w_ready
//  o_w_s        out  WIDTH  sum/difference
//  o_w_cout     out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//  o_w_ovf      out  1      signed two's-complement overflow
//  o_w_busy     out  1      1 when state != IDLE
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset (i_w_rst_n=0): state=IDLE, counter=0, carry reg=0, operand/result regs=0;
//    o_w_ready=1, o_w_valid=0, o_w_s=0, o_w_cout=0, o_w_ovf=0, o_w_busy=0.
//  - FSM states: IDLE, RUN, DONE (2-bit encoding).
//  - IDLE: o_w_ready=1. On accept, latch A, B^{WIDTH{sub}}, carry=sub?1:cin, and the MSBs
//    of A and of the modified B; set counter=0; go to RUN.
//  - RUN: o_w_ready=0. The adder sees the low nibbles of the A/B shift registers plus
//    the carry reg. Each edge: shift the sum nibble into the result reg from the top,
//    shift the A/B regs right by 4, carry<=cout, counter++. At the edge where
//    counter==NIBBLES-1, go to DONE.
//  - DONE: o_w_valid=1. o_w_s, o_w_cout and o_w_ovf are held stable until the
//    handshake completes. On i_w_ready: go to IDLE. A new request is accepted only in
//    IDLE, so there is no accept-while-DONE.
//  - Latency: o_w_valid goes high in the cycle after the NIBBLES-th RUN cycle, i.e. at
//    the NIBBLES-th edge after the accept edge. Minimum initiation interval is NIBBLES+2
//    cycles when i_w_ready is held at 1.
//  - o_w_ovf = (a_msb == bmod_msb) && (o_w_s[WIDTH-1] != a_msb), registered with the
//    last nibble.
//  - Outputs are registered except o_w_ready, o_w_valid and o_w_busy, which are decoded
//    from the state.
//  - Inputs are sampled only at accept; changes on i_w_a, i_w_b, i_w_cin, i_w_sub
//    during RUN or DONE have no effect.
//  - i_w_ready asserted outside DONE is ignored. i_w_valid outside IDLE is not
//    accepted; the requester must hold it.
//  - Reset asserted mid-RUN or mid-DONE: immediate return to the reset values; the
//    pending result is discarded.
//  - WIDTH=4: exactly one RUN cycle; the counter never increments past 0.
// STRUCTURE
//  - adder_seq_pkg.vh: state localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//  - One sub-module: adder_4bits (existing 4-full-adder ripple adder), instanced once.
//  - The FSM, counter, shift registers and carry reg live in this module.
// TESTING (WIDTH=16 unless noted)
//  1. A=0x00FF, B=0x0001, cin=0, sub=0 -> o_w_s=0x0100, cout=0, ovf=0; o_w_valid
//     rises exactly 4 edges after the accept edge.
//  2. A=0xFFFF, B=0x0001 -> s=0x0000, cout=1, ovf=0; A=0x7FFF, B=0x0001 -> s=0x8000,
//     cout=0, ovf=1.
//  3. sub=1, A=0x0005, B=0x0007, cin=1 (ignored) -> s=0xFFFE, cout=0, ovf=0;
//     sub=1, A=0x8000, B=0x0001 -> s=0x7FFF, cout=1, ovf=1.
//  4. Backpressure: hold i_w_ready=0 for 3 cycles in DONE -> s, cout, ovf and valid
//     stay stable, o_w_ready=0, and a held i_w_valid is not accepted until the cycle
//     after the handshake.
//  5. Assert i_w_rst_n=0 in the 2nd RUN cycle -> outputs return to reset values
//     immediately. After release, A=0x1234, B=0x1111 -> s=0x2345.
//  6. WIDTH=4: A=0xF, B=0x1, cin=1 -> s=0x1, cout=1, valid 1 edge after accept;
//     500 random back-to-back ops compared against a behavioural model.

Source files
------------

// File: rtl/adder_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl_pkg
// Shared types and helpers for the nibble-serial add/subtract sequencer.
//
// Contents:
//    state_e     - sequencer FSM states (IDLE, RUN, DONE) on a 2-bit encoding
//    NIB_W       - width of one adder slice (one nibble)
//    signed_ovf  - two's-complement overflow from the operand/result sign bits
// ---------------------------------------------------------------------------
package adder_seq_ctrl_pkg;

   // The sequencer sits in IDLE waiting for work, spends one cycle per nibble
   // in RUN, then parks in DONE until the consumer takes the result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // One pass of the shared adder handles this many bits.
   localparam int NIB_W = 4;

   // Overflow happens when both addends share a sign and the result's sign
   // differs from it. For subtraction, b_msb is the sign of the inverted B,
   // which is exactly the addend the adder saw.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_seq_ctrl_adder_4bits.sv
// ---------------------------------------------------------------------------
// adder_4bits
// Plain 4-bit ripple-carry adder built from four full adders. Purely
// combinational; the sequencer reuses this single slice for every nibble.
//
// Ports:
//    a    in  4  addend A nibble
//    b    in  4  addend B nibble (already inverted by the caller for subtract)
//    cin  in  1  carry into bit 0
//    s    out 4  sum nibble
//    cout out 1  carry out of bit 3
// ---------------------------------------------------------------------------
module adder_4bits
   import adder_seq_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   logic [NIB_W:0] carry;

   assign carry[0] = cin;

   // Each stage is a textbook full adder; the carry ripples from bit 0 up to
   // bit 3 so the whole slice settles within one clock period.
   for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
      assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
   end

   assign cout = carry[NIB_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adder_seq_ctrl
// WIDTH-bit add/subtract done one nibble per clock on a single shared 4-bit
// ripple adder, LSB nibble first, with the inter-nibble carry held in a
// register. Valid/ready handshakes on both the request and result sides.
// A result appears NIBBLES edges after the request is accepted.
//
// Parameters:
//    WIDTH       operand/result width, a multiple of 4 and at least 4
//
// Ports:
//    i_w_clk     in   1      clock, rising edge
//    i_w_rst_n   in   1      asynchronous reset, active low
//    i_w_valid   in   1      request valid
//    o_w_ready   out  1      request accepted when i_w_valid && o_w_ready
//    i_w_a       in   WIDTH  operand A
//    i_w_b       in   WIDTH  operand B
//    i_w_cin     in   1      carry-in, ignored for subtract
//    i_w_sub     in   1      1: A-B (B inverted, carry-in forced to 1)
//    o_w_valid   out  1      result valid
//    i_w_ready   in   1      result consumed when o_w_valid && i_w_ready
//    o_w_s       out  WIDTH  sum/difference
//    o_w_cout    out  1      carry out of the top bit (subtract: 1 = no borrow)
//    o_w_ovf     out  1      signed two's-complement overflow
//    o_w_busy    out  1      high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module adder_seq_ctrl
   import adder_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             i_w_clk,
   input  logic             i_w_rst_n,
   input  logic             i_w_valid,
   output logic             o_w_ready,
   input  logic [WIDTH-1:0] i_w_a,
   input  logic [WIDTH-1:0] i_w_b,
   input  logic             i_w_cin,
   input  logic             i_w_sub,
   output logic             o_w_valid,
   input  logic             i_w_ready,
   output logic [WIDTH-1:0] o_w_s,
   output logic             o_w_cout,
   output logic             o_w_ovf,
   output logic             o_w_busy
);

   localparam int NIBBLES = WIDTH / NIB_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   state_e           state;
   logic [CNT_W-1:0] nib_cnt;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] s_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic             cout_q;
   logic             ovf_q;

   logic [NIB_W-1:0] sum_nib;
   logic             nib_cout;
   logic [WIDTH-1:0] b_mod;
   logic [WIDTH-1:0] s_shift;

   // The single shared adder always works on the bottom nibble of the operand
   // shift registers; the registers move the next nibble down every RUN cycle.
   adder_4bits u_adder (
      .a    (a_q[NIB_W-1:0]),
      .b    (b_q[NIB_W-1:0]),
      .cin  (carry_q),
      .s    (sum_nib),
      .cout (nib_cout)
   );

   // Subtraction is A + ~B + 1, so B is inverted on the way in and the
   // carry register is preloaded with 1.
   assign b_mod = i_w_b ^ {WIDTH{i_w_sub}};

   // New sum nibbles enter at the top and slide down, so after NIBBLES passes
   // the first (least significant) nibble has reached bit 0. Written with
   // shifts so that WIDTH=4 needs no special-case slicing.
   assign s_shift = (s_q >> NIB_W) | (WIDTH'(sum_nib) << (WIDTH - NIB_W));

   // Handshake and busy flags come straight from the state so that the
   // requester and consumer see them in the same cycle the state changes.
   assign o_w_ready = (state == ST_IDLE);
   assign o_w_valid = (state == ST_DONE);
   assign o_w_busy  = (state != ST_IDLE);

   assign o_w_s    = s_q;
   assign o_w_cout = cout_q;
   assign o_w_ovf  = ovf_q;

   // Main sequencer. IDLE latches a request, RUN does one nibble per edge
   // and finishes by capturing the final carry and the overflow flag, DONE
   // holds everything stable until the consumer accepts. Operand inputs are
   // only looked at on the accept edge, so they are free to change later.
   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state   <= ST_IDLE;
         nib_cnt <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_w_valid) begin
                  a_q     <= i_w_a;
                  b_q     <= b_mod;
                  carry_q <= i_w_sub ? 1'b1 : i_w_cin;
                  a_msb_q <= i_w_a[WIDTH-1];
                  b_msb_q <= b_mod[WIDTH-1];
                  nib_cnt <= '0;
                  state   <= ST_RUN;
               end
            end

            ST_RUN: begin
               s_q     <= s_shift;
               a_q     <= a_q >> NIB_W;
               b_q     <= b_q >> NIB_W;
               carry_q <= nib_cout;
               if (nib_cnt == LAST_CNT) begin
                  // The top nibble's carry and sign bit settle the flags.
                  cout_q  <= nib_cout;
                  ovf_q   <= signed_ovf(a_msb_q, b_msb_q, sum_nib[NIB_W-1]);
                  nib_cnt <= '0;
                  state   <= ST_DONE;
               end else begin
                  nib_cnt <= nib_cnt + 1'b1;
               end
            end

            ST_DONE: begin
               if (i_w_ready) begin
                  state <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Self-checking bench for adder_seq_ctrl. Instances a 16-bit and a 4-bit copy
// of the sequencer on one clock and checks them against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_adder_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   // 16-bit instance signals
   logic        in_valid16, out_ready16, in_cin16, in_sub16;
   logic [15:0] a16, b16, s16;
   logic        out_valid16, in_ready16, cout16, ovf16, busy16;

   // 4-bit instance signals
   logic        in_valid4, out_ready4, in_cin4, in_sub4;
   logic [3:0]  a4, b4, s4;
   logic        out_valid4, in_ready4, cout4, ovf4, busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_seq_ctrl #(.WIDTH(16)) dut16 (
      .i_w_clk   (clk),
      .i_w_rst_n (rst_n),
      .i_w_valid (in_valid16),
      .o_w_ready (out_ready16),
      .i_w_a     (a16),
      .i_w_b     (b16),
      .i_w_cin   (in_cin16),
      .i_w_sub   (in_sub16),
      .o_w_valid (out_valid16),
      .i_w_ready (in_ready16),
      .o_w_s     (s16),
      .o_w_cout  (cout16),
      .o_w_ovf   (ovf16),
      .o_w_busy  (busy16)
   );

   adder_seq_ctrl #(.WIDTH(4)) dut4 (
      .i_w_clk   (clk),
      .i_w_rst_n (rst_n),
      .i_w_valid (in_valid4),
      .o_w_ready (out_ready4),
      .i_w_a     (a4),
      .i_w_b     (b4),
      .i_w_cin   (in_cin4),
      .i_w_sub   (in_sub4),
      .o_w_valid (out_valid4),
      .i_w_ready (in_ready4),
      .o_w_s     (s4),
      .o_w_cout  (cout4),
      .o_w_ovf   (ovf4),
      .o_w_busy  (busy4)
   );

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Arithmetic reference: unsigned sum for s/cout, true signed result
   // range check for overflow.
   function automatic void refModel(input int w, input longint a, input longint b,
                                    input bit cin, input bit sub,
                                    output longint s, output bit cout, output bit ovf);
      longint mask, half, bmod, total, sa, sb, r;
      mask  = (longint'(1) << w) - 1;
      half  = longint'(1) << (w - 1);
      bmod  = sub ? (~b & mask) : b;
      total = a + bmod + (sub ? longint'(1) : longint'(cin));
      s     = total & mask;
      cout  = ((total >> w) & 1) != 0;
      sa    = (a >= half) ? a - 2 * half : a;
      sb    = (b >= half) ? b - 2 * half : b;
      r     = sub ? sa - sb : sa + sb + longint'(cin);
      ovf   = (r >= half) || (r < -half);
   endfunction

   // Present a request to the 16-bit instance, wait for the accept edge,
   // then count edges until the result becomes valid.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic sub, output int lat);
      int guard;
      @(negedge clk);
      a16 = a; b16 = b; in_cin16 = cin; in_sub16 = sub; in_valid16 = 1'b1;
      guard = 0;
      while (!out_ready16 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("accept_wait16", 32'(guard < 100), 32'd1);
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic finishHandshake16();
      @(negedge clk);
      in_ready16 = 1'b1;
      @(posedge clk);
      #1;
      in_ready16 = 1'b0;
      checkOutput("hs16_idle", 32'({busy16, out_valid16, out_ready16}), 32'b001);
   endtask

   task automatic runOp16(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] exp_s,
                          input logic exp_cout, input logic exp_ovf);
      int lat;
      applyStimulus(a, b, cin, sub, lat);
      checkOutput({tag, "_lat"}, 32'(lat), 32'd4);
      checkOutput({tag, "_s"}, 32'(s16), 32'(exp_s));
      checkOutput({tag, "_cout"}, 32'(cout16), 32'(exp_cout));
      checkOutput({tag, "_ovf"}, 32'(ovf16), 32'(exp_ovf));
      finishHandshake16();
   endtask

   // 4-bit instance runs with its result ready held high, so ops go back to back.
   task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b,
                                 input logic cin, input logic sub, output int lat);
      int guard;
      @(negedge clk);
      a4 = a; b4 = b; in_cin4 = cin; in_sub4 = sub; in_valid4 = 1'b1;
      guard = 0;
      while (!out_ready4 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic runOp4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic sub, input logic [3:0] exp_s,
                         input logic exp_cout, input logic exp_ovf);
      int lat;
      applyStimulus4(a, b, cin, sub, lat);
      checkOutput({tag, "_lat"}, 32'(lat), 32'd1);
      checkOutput({tag, "_s"}, 32'(s4), 32'(exp_s));
      checkOutput({tag, "_cout"}, 32'(cout4), 32'(exp_cout));
      checkOutput({tag, "_ovf"}, 32'(ovf4), 32'(exp_ovf));
   endtask

   initial begin
      int          lat;
      longint      rs;
      bit          rc, ro;
      logic [15:0] ra, rb;
      logic [3:0]  qa, qb;
      logic        rcin, rsub;

      rst_n = 1'b0;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; in_cin16 = 1'b0; in_sub16 = 1'b0; in_ready16 = 1'b0;
      in_valid4 = 1'b0;  a4 = '0;  b4 = '0;  in_cin4 = 1'b0;  in_sub4 = 1'b0;  in_ready4 = 1'b1;

      // Reset values
      #2;
      checkOutput("rst16_flags", 32'({out_ready16, out_valid16, busy16, cout16, ovf16}), 32'b10000);
      checkOutput("rst16_s", 32'(s16), 32'h0);
      checkOutput("rst4_flags", 32'({out_ready4, out_valid4, busy4, cout4, ovf4}), 32'b10000);
      checkOutput("rst4_s", 32'(s4), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed 16-bit add/subtract cases
      runOp16("add_carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      runOp16("add_wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      runOp16("add_ovf",         16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      runOp16("sub_neg",         16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      runOp16("sub_ovf",         16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Backpressure: result held in DONE while a new request waits
      applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
      checkOutput("bp_lat", 32'(lat), 32'd4);
      a16 = 16'h0F0F; b16 = 16'h0101; in_cin16 = 1'b0; in_sub16 = 1'b0; in_valid16 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp_hold_flags", 32'({out_valid16, out_ready16, busy16}), 32'b101);
         checkOutput("bp_hold_s", 32'(s16), 32'h5555);
         checkOutput("bp_hold_co", 32'({cout16, ovf16}), 32'b00);
      end
      in_ready16 = 1'b1;
      @(posedge clk);
      #1;
      in_ready16 = 1'b0;
      checkOutput("bp_release", 32'({out_valid16, out_ready16, busy16}), 32'b010);
      @(posedge clk);
      #1;
      checkOutput("bp_accept_next", 32'({out_ready16, busy16}), 32'b01);
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("bp_next_lat", 32'(lat), 32'd4);
      checkOutput("bp_next_s", 32'(s16), 32'h1010);
      finishHandshake16();

      // Reset in the second RUN cycle discards the operation
      @(negedge clk);
      a16 = 16'h9999; b16 = 16'h8888; in_cin16 = 1'b1; in_sub16 = 1'b0; in_valid16 = 1'b1;
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mid_run_busy", 32'(busy16), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_flags", 32'({out_ready16, out_valid16, busy16, cout16, ovf16}), 32'b10000);
      checkOutput("mid_rst_s", 32'(s16), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      runOp16("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

      // Random 16-bit operations against the model
      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom); rb = 16'($urandom);
         rcin = 1'($urandom); rsub = 1'($urandom);
         refModel(16, longint'(ra), longint'(rb), rcin, rsub, rs, rc, ro);
         runOp16("rand16", ra, rb, rcin, rsub, 16'(rs), rc, ro);
      end

      // WIDTH=4 instance: directed case then back-to-back random ops
      runOp4("w4_dir", 4'hF, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0);
      for (int i = 0; i < 500; i++) begin
         qa = 4'($urandom); qb = 4'($urandom);
         rcin = 1'($urandom); rsub = 1'($urandom);
         refModel(4, longint'(qa), longint'(qb), rcin, rsub, rs, rc, ro);
         runOp4("rand4", qa, qb, rcin, rsub, 4'(rs), rc, ro);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
